// File: rtl/pipelined_alu.sv
// Handshaked RV32I ALU: registered result, IDLE/MUL/DONE control, valid/ready on both sides.
// Optional iterative shift-add MUL/MULHU enabled by defining ALU_MUL_EN.
module pipelined_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             IllegalOp
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   eval_p0;

  // Single-cycle op set; returns {illegal, result}.
  function automatic logic [WIDTH:0] alu_eval(input logic [3:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        r;
    logic                    ill;
    sa  = a;
    sb  = b;
    sh  = b[SHW-1:0];
    r   = '0;
    ill = 1'b0;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0110: r = a << sh;
      4'b0111: r = {{(WIDTH-1){1'b0}}, (sa < sb)};
      4'b1000: r = sa >>> sh;
      4'b1001: r = {{(WIDTH-1){1'b0}}, (a < b)};
      default: ill = 1'b1;
    endcase
    return {ill, r};
  endfunction

  assign eval_p0 = alu_eval(ALUControl, SrcA, SrcB);
  assign Zero    = (ALUResult == '0);

`ifdef ALU_MUL_EN
  localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0]   mcand_p0;
  logic [WIDTH-1:0]   mplier_p0;
  logic               mulhi_p0;
  logic [2*WIDTH-1:0] acc;
  logic [SHW:0]       cnt;
  logic [WIDTH:0]     mul_sum;

  assign is_mul  = (ALUControl == 4'b1010) || (ALUControl == 4'b1011);
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_p0[0] ? mcand_p0 : '0)};
`else
  assign is_mul  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    out_valid = (state == S_DONE);
    accept    = in_valid && in_ready;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)
          state_nxt = is_mul ? S_MUL : S_DONE;
        else if ((state == S_DONE) && out_ready)
          state_nxt = S_IDLE;
      end
`ifdef ALU_MUL_EN
      S_MUL: begin
        if (cnt == MUL_ITERS)
          state_nxt = S_DONE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0 -> result register: control, result and multiplier accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ALUResult <= '0;
      IllegalOp <= 1'b0;
`ifdef ALU_MUL_EN
      acc       <= '0;
      cnt       <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept && !is_mul) begin
        ALUResult <= eval_p0[WIDTH-1:0];
        IllegalOp <= eval_p0[WIDTH];
      end
`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == S_MUL) begin
        if (cnt != MUL_ITERS) begin
          acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
        end else begin
          ALUResult <= mulhi_p0 ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
          IllegalOp <= 1'b0;
        end
      end
`endif
    end
  end

`ifdef ALU_MUL_EN
  // Operand capture for the iterative multiplier; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mcand_p0  <= SrcA;
      mplier_p0 <= SrcB;
      mulhi_p0  <= ALUControl[0];
    end else if ((state == S_MUL) && (cnt != MUL_ITERS)) begin
      mplier_p0 <= mplier_p0 >> 1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_alu.sv
// Scoreboard bench for pipelined_alu: directed test-plan vectors plus randomized ops
// with random back-pressure, checked against a behavioural model.
module tb_pipelined_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  SrcA;
  logic [W-1:0]  SrcB;
  logic [3:0]    ALUControl;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  ALUResult;
  logic          Zero;
  logic          IllegalOp;

  typedef struct packed {
    logic         ill;
    logic [W-1:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   rnd_done = 1'b0;

  pipelined_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .Zero(Zero), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic on the encoding table.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    logic [4:0]  sh;
    e.ill = 1'b0;
    e.r   = '0;
    sh    = b[4:0];
    p     = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  e.r = a + b;
      4'd1:  e.r = a - b;
      4'd2:  e.r = a & b;
      4'd3:  e.r = a | b;
      4'd4:  e.r = a ^ b;
      4'd5:  e.r = a >> sh;
      4'd6:  e.r = a << sh;
      4'd7:  e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  e.r = $signed(a) >>> sh;
      4'd9:  e.r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
      4'd10: e.r = p[31:0];
      4'd11: e.r = p[63:32];
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=no_output", ALUResult);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", ALUResult, e.r);
        chk("sb_flags", {IllegalOp, Zero}, {e.ill, (e.r == '0)});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int waited);
    waited     = 0;
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout actual=in_ready_low required=accept");
        break;
      end
    end
    if (waited <= 200) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int edges, output int busy_rdy);
    edges    = -1;
    busy_rdy = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (out_valid) begin
        edges = k;
        break;
      end
      if (in_ready) busy_rdy++;
    end
  endtask

  task automatic dir(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_ill,
                     input int exp_lat);
    int w, e, br;
    send(op, a, b, w);
    wait_out(e, br);
    chk({name, "_res"}, ALUResult, exp_r);
    chk({name, "_zero"}, Zero, (exp_r == '0));
    chk({name, "_ill"}, IllegalOp, exp_ill);
    chk({name, "_lat"}, e, exp_lat);
    if (exp_lat > 0) chk({name, "_busy_ready"}, br, 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int w, e, br;
    logic [W-1:0] held;
    in_valid   = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = 4'd0;
    out_ready  = 1'b1;
    reset      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", Zero, 1);
    chk("rst_illegal", IllegalOp, 0);
    @(posedge clk);
    #1;

    dir("add_wrap", 4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 0);
    dir("sub_zero", 4'd1, 32'd5, 32'd5, 32'h0, 1'b0, 0);
    dir("sra", 4'd8, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 0);
    dir("srl", 4'd5, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 0);
    dir("slt", 4'd7, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 0);
    dir("sltu", 4'd9, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 0);
    dir("sll", 4'd6, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0);
    dir("xor", 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1'b0, 0);
    dir("or", 4'd3, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 0);
    dir("illegal_f", 4'hF, 32'h1234, 32'h5678, 32'h0, 1'b1, 0);
`ifdef ALU_MUL_EN
    dir("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, W + 1);
    dir("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, W + 1);
    dir("mul_small", 4'd10, 32'd1234, 32'd5678, 32'd7006652, 1'b0, W + 1);
`else
    dir("op1010_illegal", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
    dir("op1011_illegal", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
`endif

    // Back-pressure then back-to-back acceptance
    out_ready = 1'b0;
    send(4'd0, 32'h1234, 32'h1, w);
    wait_out(e, br);
    chk("bp_lat", e, 0);
    chk("bp_first", ALUResult, 32'h1235);
    held = ALUResult;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_result", ALUResult, held);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'd2, 32'hF0F0, 32'hFF00, w);
    chk("b2b_accept_wait", w, 0);
    wait_out(e, br);
    chk("b2b_lat", e, 0);
    chk("b2b_and", ALUResult, 32'hF000);
    @(posedge clk);
    #1;

    // Reset while busy discards the op
`ifdef ALU_MUL_EN
    send(4'd10, 32'hDEAD_BEEF, 32'h1234_5678, w);
`else
    out_ready = 1'b0;
    send(4'd0, 32'hDEAD_BEEF, 32'h1234_5678, w);
`endif
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_busy_out_valid", out_valid, 0);
    chk("rst_busy_in_ready", in_ready, 1);
    chk("rst_busy_result", ALUResult, 0);
    @(posedge clk);
    #1;
    dir("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 0);

    // Randomized traffic with random back-pressure
    fork
      begin
        int rw;
        logic [3:0] op;
        for (int i = 0; i < 150; i++) begin
          op = 4'($urandom_range(0, 15));
          send(op, pick(), pick(), rw);
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, handshaked successor to the single-cycle combinational ALU: registered result, valid/ready on both sides, full RV32I op set plus an iterative shift-add multiplier.
- Sits between operand select and writeback in the multi-cycle datapath.
- Execute stage stalls on in_ready and consumes results on out_valid.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, at least 8.
SHW, $clog2(WIDTH), shift-amount bits taken from SrcB; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and op are valid this cycle
in_ready  output  1  block can accept an op this cycle
SrcA  input  WIDTH  operand A
SrcB  input  WIDTH  operand B
ALUControl  input  4  operation select
out_valid  output  1  result registers hold a completed op
out_ready  input  1  consumer takes the result this cycle
ALUResult  output  WIDTH  registered result
Zero  output  1  ALUResult == 0, registered with ALUResult
IllegalOp  output  1  completed op had an unsupported encoding

Behaviour:
- Encodings:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR; 0101 SRL; 0110 SLL; 0111 SLT (signed); 1000 SRA; 1001 SLTU; 1010 MUL (low WIDTH bits); 1011 MULHU (high WIDTH bits, unsigned).
  - All others are illegal.
- Shifts use SrcB[SHW-1:0] only; upper bits ignored. SLT/SLTU produce 0 or 1 zero-extended. ADD/SUB wrap modulo 2^WIDTH with no carry-out.
- States: IDLE, MUL, DONE.
  - IDLE: in_ready=1.
    - Accept (in_valid) of a non-MUL op computes combinationally and registers ALUResult/Zero/IllegalOp, then goes to DONE. Latency 1: out_valid high the cycle after acceptance.
    - Accept of MUL/MULHU latches SrcA, SrcB and op, clears the 2*WIDTH product accumulator and counter, then goes to MUL.
  - MUL: in_ready=0.
    - Each cycle: if multiplier LSB is set, add multiplicand to the accumulator upper half (carry kept); shift accumulator right by 1.
    - After exactly WIDTH iterations, select the low or high half into ALUResult and go to DONE.
    - Acceptance edge N gives out_valid high after edge N+WIDTH+1.
  - DONE: out_valid=1; ALUResult, Zero and IllegalOp held stable until out_ready.
    - out_ready=0: stay in DONE.
    - out_ready=1, in_valid=0: go to IDLE.
    - out_ready=1 with in_valid=1 (back-to-back): in_ready=1 and the new op is accepted the same cycle. Non-MUL goes to DONE with the new result; MUL goes to MUL. Throughput is one non-MUL op per cycle.
- Illegal op: result 0, Zero=1, IllegalOp=1, latency 1, no trap.
- Zero is always derived from the registered ALUResult value.
- Reset, sampled at a rising edge, has priority over everything:
  - Outputs: state IDLE, out_valid=0, ALUResult=0, Zero=1, IllegalOp=0.
  - Internals: accumulator and counter cleared.
  - An in-flight MUL is discarded with no output.
- in_ready is combinational from state and out_ready. No combinational path from in_valid to in_ready.
- SrcA/SrcB/ALUControl are sampled only on acceptance; changes while busy have no effect.

Optional Feature:
Macro ALU_MUL_EN.
- Defined: MUL/MULHU and the MUL state exist as above.
- Undefined: 1010/1011 are illegal (result 0, Zero=1, IllegalOp=1, latency 1). The MUL state, accumulator and counter are not synthesised.

Test Plan:
- Reset, then WIDTH=32: ADD 0x7FFFFFFF+0x1 -> after 1 cycle, ALUResult=0x80000000, Zero=0. SUB 5-5 -> 0, Zero=1.
- SRA 0x80000000, SrcB=0x24 (amount 4) -> 0xF8000000. SRL same inputs -> 0x08000000. SLT 0xFFFFFFFF,1 -> 1. SLTU same -> 0.
- ALU_MUL_EN defined: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. MULHU same -> 0xFFFFFFFE. Both take out_valid after exactly 33 cycles, with in_ready=0 throughout.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> ALUResult stable, in_ready=0. Then out_ready=1 with in_valid=1 (AND 0xF0F0,0xFF00) -> accepted that cycle, next result 0xF000.
- Illegal 1111 -> IllegalOp=1, ALUResult=0, Zero=1. Without ALU_MUL_EN, 1010 behaves identically.
- Assert reset at iteration 10 of a MUL -> next cycle out_valid=0, in_ready=1, ALUResult=0. A following ADD 2+3 returns 5 normally.
